mem_store_unit: RTL
===================

Name: mem_store_unit

Overview:
- Parametrised successor to the single-word write-strobe generator.
- Takes store requests from the MEM stage: byte/half/word/dword stores, plus MIPS store-left (SWL) and store-right (SWR) in a configurable bus width.
- Computes the byte strobe and the lane-aligned write data for each request, and queues the result in a DEPTH-entry store buffer.
- Issues queued stores to an SRAM-like data bus (req/addr_ok/data_ok) and tracks outstanding writes, so the pipeline stalls only when the buffer is full.

Parameters:
- DATA_W, 32, data bus width in bits; must be 32 or 64. NB = DATA_W/8 byte lanes; OFF_W = log2(NB).
- ADDR_W, 32, byte address width.
- DEPTH, 4, store buffer entries; power of two, at least 2.
- MAX_OUT, 2, maximum writes issued and awaiting data_ok; at least 1.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- resetn, input, 1, asynchronous active-low reset.
- in_valid, input, 1, store request valid.
- in_ready, output, 1, buffer can accept a request.
- in_addr, input, ADDR_W, byte address.
- in_size, input, 2, 0 = byte, 1 = half, 2 = word, 3 = dword (legal only when DATA_W=64).
- in_mode, input, 2, 0 = normal, 1 = left (SWL), 2 = right (SWR), 3 = reserved.
- in_data, input, DATA_W, register data, LSB-justified.
- in_err, output, 1, one-cycle pulse: request dropped (misaligned, illegal size, or reserved mode).
- bus_req, output, 1, write request valid.
- bus_addr, output, ADDR_W, in_addr with the low OFF_W bits cleared.
- bus_wstrb, output, NB, byte strobe.
- bus_wdata, output, DATA_W, lane-aligned data.
- bus_addr_ok, input, 1, address/data accepted this cycle.
- bus_data_ok, input, 1, one write completed.
- idle, output, 1, buffer empty and zero writes outstanding.

Behaviour:
- Reset (resetn low, asynchronous): buffer empty, outstanding count 0, in_err=0, bus_req=0, in_ready=1, idle=1. bus_addr, bus_wstrb and bus_wdata read 0.
- Interface: the clock and reset ports are clk and resetn; reset is asynchronous and active-low, with one clock domain.
- Accept: a request is accepted when in_valid && in_ready. in_ready = !full; there is no same-cycle pass-through when full, even if a pop occurs that cycle.
- Validity check, applied on an accepted request with mode normal: o = in_addr[OFF_W-1:0] must be a multiple of 2^in_size.
  - Dropped with in_err=1 on the next cycle, and nothing enqueued, when any of these holds: the offset is misaligned; in_size=3 with DATA_W=32; in_mode=3.
- Left and right modes always use a word size. For DATA_W=64, L = 4 × addr[2] and w = addr[1:0].
- Strobe and data per accepted legal request:
  - normal: strobe = (2^(2^size) - 1) << o; data = in_data << 8o.
  - left: strobe = lanes L..L+w set; data = (in_data >> 8(3-w)) << 8L.
  - right: strobe = lanes L+w..L+3 set; data = in_data << 8(L+w).
  - Unused lanes of data are 0; all shifts are truncated to DATA_W.
- Enqueue: the registered entry is visible at the head one cycle after acceptance at the earliest (latency 1 to bus_req).
- Issue: bus_req = !empty && (out_cnt < MAX_OUT). Pop on bus_req && bus_addr_ok.
- While bus_req=1 and bus_addr_ok=0, bus_addr, bus_wstrb and bus_wdata are held stable.
- Outstanding count: out_cnt increments on pop and decrements on bus_data_ok; both in the same cycle leave it unchanged.
  - bus_data_ok with out_cnt=0 is ignored, the count stays 0, and the verification assertion flags it.
- Buffer is a circular FIFO with wrap-around pointers; the full/empty distinction uses an extra pointer bit.
  - Simultaneous push and pop when non-full keeps the count unchanged.
- idle = empty && out_cnt==0, computed combinationally from state.
- Reset mid-operation discards all buffered and outstanding state immediately.

Optional Feature:
- Macro: STORE_FWD_EN.
- Enabled, adds ports:
  - probe_addr, input, ADDR_W.
  - probe_hit, output, 1: combinational, 1 when any valid buffer entry or the head being issued has bus_addr equal to probe_addr with low bits cleared.
  - The load path stalls on a hit. Only entries that have not yet been popped are compared.
- Disabled: the ports are absent and there is no comparator logic.

Test Plan:
- DATA_W=32, word store to addr 0x100 with data 0xAABBCCDD, addr_ok tied to 1 → next cycle bus_req=1, bus_addr=0x100, wstrb=1111, wdata=0xAABBCCDD.
- SWL at addr 0x201 with data 0x11223344 → wstrb=0011, wdata=0x00001122. SWR at addr 0x201 → wstrb=1110, wdata=0x22334400.
- DATA_W=64, half store at addr 0x06 with data 0xBEEF → wstrb=0xC0, wdata=0xBEEF<<48. Half store at addr 0x05 → in_err pulse, nothing issued.
- DEPTH=4, addr_ok held 0, five back-to-back requests → in_ready=0 after the fourth. Releasing addr_ok pops them in order and resumes acceptance.
- MAX_OUT=2, addr_ok=1, data_ok withheld → only 2 pops, then bus_req=0. One data_ok pulse → one more pop. idle=1 only after the final data_ok.
- resetn pulled low with 3 entries buffered → all outputs return to reset values asynchronously, and idle=1 before the next edge.

Source files
------------

// File: rtl/mem_store_unit.sv
// Store unit: turns MEM-stage store requests into byte strobes and lane-aligned data, buffers them,
// and issues them on an SRAM-like write bus. Optional macro STORE_FWD_EN adds a load-probe comparator.
module mem_store_unit #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MAX_OUT = 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDR_W-1:0]      in_addr,
    input  logic [1:0]             in_size,
    input  logic [1:0]             in_mode,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   in_err,
    output logic                   bus_req,
    output logic [ADDR_W-1:0]      bus_addr,
    output logic [DATA_W/8-1:0]    bus_wstrb,
    output logic [DATA_W-1:0]      bus_wdata,
    input  logic                   bus_addr_ok,
`ifdef STORE_FWD_EN
    input  logic [ADDR_W-1:0]      probe_addr,
    output logic                   probe_hit,
`endif
    input  logic                   bus_data_ok,
    output logic                   idle
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

    logic              legal;
    logic [NB-1:0]     strb;
    logic [DATA_W-1:0] raw;
    logic [DATA_W-1:0] wdata;
    int unsigned       off;
    int unsigned       lane_l;
    int unsigned       w;
    int unsigned       sz;

    // Request decode: strobe, shifted data and legality.
    always_comb begin
        off    = 32'(in_addr[OFF_W-1:0]);
        lane_l = (NB == 8) ? 32'(in_addr[OFF_W-1]) * 4 : 0;
        w      = 32'(in_addr[1:0]);
        sz     = 32'(in_size);
        legal  = 1'b1;
        strb   = '0;
        raw    = '0;
        case (in_mode)
            2'd0: begin
                if (((off >> sz) << sz) != off) legal = 1'b0;
                if (sz == 3 && NB == 4) legal = 1'b0;
                for (int i = 0; i < NB; i++) begin
                    strb[i] = (i >= off) && (i < off + (1 << sz));
                end
                raw = in_data << (8 * off);
            end
            2'd1: begin
                for (int i = 0; i < NB; i++) begin
                    strb[i] = (i >= lane_l) && (i <= lane_l + w);
                end
                raw = (in_data >> (8 * (3 - w))) << (8 * lane_l);
            end
            2'd2: begin
                for (int i = 0; i < NB; i++) begin
                    strb[i] = (i >= lane_l + w) && (i <= lane_l + 3);
                end
                raw = in_data << (8 * (lane_l + w));
            end
            default: legal = 1'b0;
        endcase
        // Lanes outside the strobe always carry zero.
        for (int i = 0; i < NB; i++) begin
            wdata[8*i +: 8] = strb[i] ? raw[8*i +: 8] : 8'h00;
        end
    end

    logic [PTR_W:0]      wr_q, rd_q;
    logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
    logic                in_err_q;
    logic                empty, full, accept, push, pop, dok_eff;
    logic [ADDR_W-1:0]   addr_mem [DEPTH];
    logic [NB-1:0]       strb_mem [DEPTH];
    logic [DATA_W-1:0]   data_mem [DEPTH];

    assign empty    = (wr_q == rd_q);
    assign full     = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                      (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
    assign in_ready = !full;
    assign accept   = in_valid && in_ready;
    assign push     = accept && legal;
    assign bus_req  = !empty && (out_cnt_q < CNT_W'(MAX_OUT));
    assign pop      = bus_req && bus_addr_ok;
    assign dok_eff  = bus_data_ok && (out_cnt_q != '0);
    assign in_err   = in_err_q;
    assign idle     = empty && (out_cnt_q == '0);

    // Head outputs read zero while empty so reset state is clean without resetting storage.
    assign bus_addr  = empty ? '0 : addr_mem[rd_q[PTR_W-1:0]];
    assign bus_wstrb = empty ? '0 : strb_mem[rd_q[PTR_W-1:0]];
    assign bus_wdata = empty ? '0 : data_mem[rd_q[PTR_W-1:0]];

    always_comb begin
        out_cnt_d = out_cnt_q;
        if (pop && !dok_eff) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end else if (!pop && dok_eff) begin
            out_cnt_d = out_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q      <= '0;
            rd_q      <= '0;
            out_cnt_q <= '0;
            in_err_q  <= 1'b0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            out_cnt_q <= out_cnt_d;
            in_err_q  <= accept && !legal;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_q[PTR_W-1:0]] <= {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            strb_mem[wr_q[PTR_W-1:0]] <= strb;
            data_mem[wr_q[PTR_W-1:0]] <= wdata;
        end
    end

`ifdef STORE_FWD_EN
    logic [PTR_W:0]   fill;
    logic [PTR_W-1:0] rel;

    assign fill = wr_q - rd_q;

    // An entry is live when its distance from the read pointer is below the fill level.
    always_comb begin
        probe_hit = 1'b0;
        rel       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel = PTR_W'(i) - rd_q[PTR_W-1:0];
            if (({1'b0, rel} < fill) &&
                (addr_mem[i] == {probe_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}})) begin
                probe_hit = 1'b1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    spurious_data_ok: assert property (@(posedge clk) disable iff (!resetn)
        !(bus_data_ok && out_cnt_q == '0))
        else $error("bus_data_ok with no write outstanding");
`endif

endmodule
